// File: rtl/fixed_to_ieee754_converter.sv
// Fixed-point Q(INTEGER_WIDTH).(DECIMAL_WIDTH) two's complement to IEEE-754 single converter.
// Iterative normaliser, valid/ready on both sides. Define ROUND_NEAREST_EN for RNE rounding.
module fixed_to_ieee754_converter #(
  parameter int unsigned INTEGER_WIDTH = 8,
  parameter int unsigned DECIMAL_WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INTEGER_WIDTH-1:0] in_integer,
  input  logic [DECIMAL_WIDTH-1:0] in_decimal,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_float,
  output logic                     out_zero
);

  localparam int unsigned W  = INTEGER_WIDTH + DECIMAL_WIDTH;
  localparam int unsigned KW = $clog2(W);
  localparam int unsigned RW = W - 24;

  typedef enum logic [1:0] {StIdle, StNorm, StPack, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  mag_q, mag_d;
  logic [KW-1:0] k_q, k_d;
  logic          sign_q, sign_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_float_q, out_float_d;
  logic          out_zero_q, out_zero_d;

  logic [W-1:0]  value;
  logic [W-1:0]  abs_value;
  logic [22:0]   frac_trunc;
  logic [7:0]    exp_base;
  logic [22:0]   frac_packed;
  logic [7:0]    exp_packed;

  assign value     = {in_integer, in_decimal};
  // Most negative input wraps to 2^(W-1), which still fits as an unsigned magnitude.
  assign abs_value = value[W-1] ? ((~value) + W'(1)) : value;

  assign frac_trunc = mag_q[W-2:W-24];
  assign exp_base   = 8'(127 + INTEGER_WIDTH - 1) - 8'(k_q);

`ifdef ROUND_NEAREST_EN
  logic [RW-1:0] rbits;
  logic          guard_bit;
  logic          sticky_bit;
  logic          round_up;
  logic [23:0]   frac_sum;

  assign rbits      = mag_q[RW-1:0];
  assign guard_bit  = rbits[RW-1];
  assign sticky_bit = |(rbits << 1);
  assign round_up   = guard_bit & (sticky_bit | frac_trunc[0]);
  assign frac_sum   = {1'b0, frac_trunc} + 24'(round_up);
  // A carry out of the fraction leaves frac at zero and bumps the exponent.
  assign frac_packed = frac_sum[22:0];
  assign exp_packed  = exp_base + 8'(frac_sum[23]);
`else
  assign frac_packed = frac_trunc;
  assign exp_packed  = exp_base;
`endif

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    k_d         = k_q;
    sign_d      = sign_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_float_d = out_float_q;
    out_zero_d  = out_zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          sign_d     = value[W-1];
          mag_d      = abs_value;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = StNorm;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      StNorm: begin
        if ((mag_q == '0) || mag_q[W-1]) begin
          state_d = StPack;
        end else begin
          mag_d = mag_q << 1;
          k_d   = k_q + KW'(1);
        end
      end
      StPack: begin
        if (mag_q == '0) begin
          out_float_d = 32'h0;
          out_zero_d  = 1'b1;
        end else begin
          out_float_d = {sign_q, exp_packed, frac_packed};
          out_zero_d  = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mag_q       <= '0;
      k_q         <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_float_q <= 32'h0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      k_q         <= k_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_float_q <= out_float_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_float = out_float_q;
  assign out_zero  = out_zero_q;

endmodule
